// File: rtl/clk_div_hub.sv
// clk_div_hub: CHANNELS run-time programmable dividers, each producing a one-clock tick and a 50% divided clock.
// Optional build macro CLK_DIV_HUB_CASCADE_EN: channel i>0 advances only on tick[i-1] (decade chain).
module clk_div_hub #(
    parameter int CHANNELS  = 8,
    parameter int CNT_W     = 24,
    parameter int DIV_RESET = 10,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic                cfg_err,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                sync_restart,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] div_clk,
    output logic [CHANNELS-1:0] busy
);

    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic                cfg_bad_s;
    logic                cfg_acc_s;
    logic                cfg_err_d;
    logic                cfg_err_q;
    logic [CHANNELS-1:0] tick_v;

    // Classify the incoming divisor write as accepted or rejected.
    always_comb begin
        cfg_bad_s = (cfg_div == CNT_ZERO) || ({1'b0, cfg_ch} >= CH_LIMIT);
        cfg_acc_s = cfg_we & ~cfg_bad_s;
        cfg_err_d = cfg_we & cfg_bad_s;
    end

    // Rejection pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;
    assign tick    = tick_v;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] act_q, act_d;
        logic [CNT_W-1:0] shd_q, shd_d;
        logic             pend_q, pend_d;
        logic             tick_q, tick_d;
        logic             dclk_q, dclk_d;
        logic             adv_s, wr_s, wrap_s, apply_s;

        assign wr_s = cfg_acc_s && (cfg_ch == CH_W'(i));

`ifdef CLK_DIV_HUB_CASCADE_EN
        if (i == 0) begin : g_root
            assign adv_s = ch_en[i];
        end else begin : g_link
            assign adv_s = ch_en[i] & tick_v[i-1];
        end
`else
        assign adv_s = ch_en[i];
`endif

        // Counter, divisor hand-over and output next-state; a pending divisor lands only at a period boundary.
        always_comb begin
            wrap_s  = adv_s && (cnt_q >= (act_q - CNT_ONE));
            apply_s = pend_q && (sync_restart || wrap_s || !ch_en[i]);
            act_d   = apply_s ? shd_q : act_q;
            shd_d   = wr_s ? cfg_div : shd_q;
            pend_d  = wr_s | (pend_q & ~apply_s);
            cnt_d   = cnt_q;
            tick_d  = 1'b0;
            dclk_d  = dclk_q;
            if (sync_restart) begin
                cnt_d  = CNT_ZERO;
                dclk_d = 1'b0;
            end else if (adv_s) begin
                cnt_d  = wrap_s ? CNT_ZERO : (cnt_q + CNT_ONE);
                tick_d = wrap_s;
                dclk_d = (cnt_d >= (act_d >> 1));
            end else begin
                cnt_d  = cnt_q;
            end
        end

        // Per-channel state registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= CNT_ZERO;
                act_q  <= DIV_INIT;
                shd_q  <= DIV_INIT;
                pend_q <= 1'b0;
                tick_q <= 1'b0;
                dclk_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                act_q  <= act_d;
                shd_q  <= shd_d;
                pend_q <= pend_d;
                tick_q <= tick_d;
                dclk_q <= dclk_d;
            end
        end

        assign tick_v[i]  = tick_q;
        assign div_clk[i] = dclk_q;
        assign busy[i]    = pend_q;
    end

endmodule

// File: tb/tb_clk_div_hub.sv
// Bench for clk_div_hub: period/phase model checked every cycle, plus hand-computed tick timing literals.
module tb_clk_div_hub;
    localparam int CH  = 3;
    localparam int CW  = 8;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_err;
    logic [CH-1:0]  ch_en;
    logic           sync_restart;
    logic [CH-1:0]  tick, div_clk, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model: position inside the current period, divisor in use, requested divisor
    int            m_pos [CH];
    int            m_div [CH];
    int            m_shd [CH];
    logic [CH-1:0] m_pend, e_tick, e_dclk;
    logic          e_err;

    int tq[$];
    int uq[$];
    int hq[$];
    int hc, first_b, cnt_a, cnt_b, f0, f1, f2;

    clk_div_hub #(.CHANNELS(CH), .CNT_W(CW), .DIV_RESET(10)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_err(cfg_err), .ch_en(ch_en), .sync_restart(sync_restart),
        .tick(tick), .div_clk(div_clk), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_pos[c] = 0;
            m_div[c] = 10;
            m_shd[c] = 10;
        end
        m_pend = '0;
        e_tick = '0;
        e_dclk = '0;
        e_err  = 1'b0;
    endtask

    // advance the model by one clock from the applied inputs, then compare after the edge
    task automatic step();
        for (int c = CH - 1; c >= 0; c--) begin
            bit adv, wrap, ap;
            int nd;
            adv = ch_en[c];
`ifdef CLK_DIV_HUB_CASCADE_EN
            if (c > 0) adv = adv && e_tick[c-1];
`endif
            wrap = adv && (m_pos[c] == m_div[c] - 1);
            ap   = m_pend[c] && (sync_restart || wrap || !ch_en[c]);
            nd   = ap ? m_shd[c] : m_div[c];
            if (sync_restart) begin
                m_pos[c]  = 0;
                e_tick[c] = 1'b0;
                e_dclk[c] = 1'b0;
            end else if (adv) begin
                m_pos[c]  = (m_pos[c] + 1) % m_div[c];
                e_tick[c] = (m_pos[c] == 0);
                e_dclk[c] = (m_pos[c] >= nd / 2);
            end else begin
                e_tick[c] = 1'b0;
            end
            m_div[c] = nd;
            if (ap) m_pend[c] = 1'b0;
        end
        e_err = 1'b0;
        if (cfg_we) begin
            if (cfg_div == 0 || cfg_ch >= CH) begin
                e_err = 1'b1;
            end else begin
                m_shd[cfg_ch]  = int'(cfg_div);
                m_pend[cfg_ch] = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("tick", tick, e_tick);
        chk("div_clk", div_clk, e_dclk);
        chk("busy", busy, m_pend);
        chk("cfg_err", cfg_err, e_err);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        ch_en = '1; sync_restart = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #20;
        chk("rst_tick", tick, 32'd0);
        chk("rst_div_clk", div_clk, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_cfg_err", cfg_err, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;

`ifdef CLK_DIV_HUB_CASCADE_EN
        for (int k = 0; k < 2100; k++) begin
            step();
            if (tick[1]) tq.push_back(cyc);
            if (tick[2]) uq.push_back(cyc);
        end
        chk("casc_t1_count", (tq.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
        chk("casc_t2_count", (uq.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
        if (tq.size() >= 2 && uq.size() >= 2) begin
            chk("casc_t1_first", tq[0], 32'd101);
            chk("casc_t1_period", tq[1] - tq[0], 32'd100);
            chk("casc_t2_first", uq[0], 32'd1002);
            chk("casc_t2_period", uq[1] - uq[0], 32'd1000);
        end
`else
        // defaults: tick0 at 10, 20, 30; div_clk low 5 / high 5
        hc = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (tick[0]) tq.push_back(cyc);
            if (cyc > 10 && cyc <= 20 && div_clk[0]) hc++;
        end
        chk("t1_tick_count", tq.size(), 32'd3);
        if (tq.size() == 3) begin
            chk("t1_first_tick", tq[0], 32'd10);
            chk("t1_second_tick", tq[1], 32'd20);
        end
        chk("t1_dclk_high", hc, 32'd5);

        // ch2 div=4 written at cnt=3
        for (int k = 0; k < 3; k++) step();
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd4;
        step();
        cfg_we = 1'b0;
        chk("t2_busy_set", busy[2], 32'd1);
        tq.delete();
        first_b = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (tick[2]) tq.push_back(cyc);
            if (!busy[2] && first_b == 0) first_b = cyc;
        end
        chk("t2_tick_count", tq.size(), 32'd3);
        if (tq.size() == 3) begin
            chk("t2_wrap_tick", tq[0], 32'd40);
            chk("t2_new_period", tq[1] - tq[0], 32'd4);
        end
        chk("t2_busy_drop", first_b, 32'd40);

        // rejected writes
        cnt_a = 0;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
        step(); if (cfg_err) cnt_a++;
        cfg_ch = 2'd3; cfg_div = 8'd5;
        step(); if (cfg_err) cnt_a++;
        cfg_we = 1'b0;
        step(); if (cfg_err) cnt_a++;
        chk("t3_err_pulses", cnt_a, 32'd2);
        chk("t3_busy", busy, 32'd0);

        // ch1 div=3 then div=7 before the wrap: last wins
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
        step();
        cfg_div = 8'd7;
        step();
        cfg_we = 1'b0;
        tq.delete(); hq.delete(); hc = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (div_clk[1]) hc++;
            if (tick[1]) begin
                tq.push_back(cyc);
                hq.push_back(hc);
                hc = 0;
            end
        end
        chk("t4_tick_count", (tq.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        if (tq.size() >= 3) begin
            chk("t4_wrap_tick", tq[0], 32'd60);
            chk("t4_period", tq[1] - tq[0], 32'd7);
            chk("t4_period2", tq[2] - tq[1], 32'd7);
            chk("t4_dclk_high", hq[1], 32'd4);
        end

        // ch0 disabled at cnt=6 for 5 clks, then sync_restart
        for (int k = 0; k < 10 && m_pos[0] != 6; k++) step();
        chk("t5_align", m_pos[0], 32'd6);
        ch_en = 3'b110;
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd10;
        step(); chk("t5_dis_tick", tick[0], 32'd0);
        cfg_ch = 2'd2;
        step(); chk("t5_dis_tick", tick[0], 32'd0);
        cfg_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_dis_tick", tick[0], 32'd0);
        end
        ch_en = 3'b111; sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        chk("t5_rs_tick", tick, 32'd0);
        chk("t5_rs_dclk", div_clk, 32'd0);
        cnt_b = cyc; f0 = 0; f1 = 0; f2 = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (tick[0] && f0 == 0) f0 = cyc - cnt_b;
            if (tick[1] && f1 == 0) f1 = cyc - cnt_b;
            if (tick[2] && f2 == 0) f2 = cyc - cnt_b;
        end
        chk("t5_realign0", f0, 32'd10);
        chk("t5_realign1", f1, 32'd10);
        chk("t5_realign2", f2, 32'd10);

        // boundaries: div=1 on ch1, div=2^CNT_W-1 on ch2
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd1;
        step();
        cfg_ch = 2'd2; cfg_div = 8'd255;
        step();
        cfg_we = 1'b0; sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        cnt_b = cyc; cnt_a = 0; hc = 0; f2 = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (tick[1]) cnt_a++;
            if (div_clk[1]) hc++;
            if (tick[2] && f2 == 0) f2 = cyc - cnt_b;
        end
        chk("t7_div1_ticks", cnt_a, 32'd256);
        chk("t7_div1_dclk", hc, 32'd256);
        chk("t7_div255_tick", f2, 32'd255);

        // async reset mid-run drops a pending write and restores defaults
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
        step();
        cfg_we = 1'b0;
        chk("t6_busy_pend", busy[0], 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_tick", tick, 32'd0);
        chk("t6_rst_dclk", div_clk, 32'd0);
        chk("t6_rst_busy", busy, 32'd0);
        chk("t6_rst_err", cfg_err, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; f0 = 0; f1 = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (tick[0] && f0 == 0) f0 = cyc;
            if (tick[1] && f1 == 0) f1 = cyc;
        end
        chk("t6_first_tick0", f0, 32'd10);
        chk("t6_first_tick1", f1, 32'd10);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
